// File: rtl/id_ex_elastic_reg.sv
// id_ex_elastic_reg
//   Decode->Execute pipeline register with a valid/ready handshake.
//   A main entry drives the EX-side outputs directly, and a skid entry absorbs
//   one overflow instruction, so back-pressure from EX never drops an
//   instruction. in_ready is a flop (~skid_valid), so there is no
//   combinational path from out_ready to in_ready.
//   flush squashes both held entries and any incoming entry. Held entries
//   become bubbles: ctrl_out is cleared and the data fields keep their values.
//   Whenever out_valid is 0, ctrl_out is all zeros.
// Optional feature: define ID_EX_PERF_CNT_EN to add the saturating
//   stall_cnt and flush_cnt counters (CNT_W bits wide).
// Ports
//   clk, rst (async active-high), flush
//   in_valid/in_ready  + ctrl_in, npc_in, rd1_in, rd2_in, sigext_in, rs/rt/rd_in
//   out_valid/out_ready + matching *_out fields
//   stall_cnt, flush_cnt (only when ID_EX_PERF_CNT_EN is defined)
module id_ex_elastic_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_A_W = 5,
  parameter int ALUOP_W = 6
`ifdef ID_EX_PERF_CNT_EN
  ,parameter int CNT_W  = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALUOP_W+7:0]   ctrl_in,
  input  logic [DATA_W-1:0]    npc_in,
  input  logic [DATA_W-1:0]    rd1_in,
  input  logic [DATA_W-1:0]    rd2_in,
  input  logic [DATA_W-1:0]    sigext_in,
  input  logic [REG_A_W-1:0]   rs_in,
  input  logic [REG_A_W-1:0]   rt_in,
  input  logic [REG_A_W-1:0]   rd_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALUOP_W+7:0]   ctrl_out,
  output logic [DATA_W-1:0]    npc_out,
  output logic [DATA_W-1:0]    rd1_out,
  output logic [DATA_W-1:0]    rd2_out,
  output logic [DATA_W-1:0]    sigext_out,
  output logic [REG_A_W-1:0]   rs_out,
  output logic [REG_A_W-1:0]   rt_out,
  output logic [REG_A_W-1:0]   rd_out
`ifdef ID_EX_PERF_CNT_EN
  ,output logic [CNT_W-1:0]    stall_cnt
  ,output logic [CNT_W-1:0]    flush_cnt
`endif
);

  localparam int CW = ALUOP_W + 8;
  localparam int PW = CW + 4*DATA_W + 3*REG_A_W;

  // Each entry is one packed vector with ctrl in the top bits.
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic          main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic          rdy_q, rdy_d;
  logic          in_fire, out_fire;

  assign in_pl = {ctrl_in, npc_in, rd1_in, rd2_in, sigext_in, rs_in, rt_in, rd_in};

  assign in_ready  = rdy_q;
  assign out_valid = main_v_q;
  assign {ctrl_out, npc_out, rd1_out, rd2_out, sigext_out, rs_out, rt_out, rd_out} = main_q;

  always_comb begin
    in_fire  = in_valid & rdy_q & ~flush;
    out_fire = main_v_q & out_ready;
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case ({main_v_q, skid_v_q})
        2'b00: if (in_fire) begin
          main_d   = in_pl;
          main_v_d = 1'b1;
        end
        2'b10: begin
          if (out_fire) begin
            if (in_fire) main_d   = in_pl;
            else         main_v_d = 1'b0;
          end else if (in_fire) begin
            skid_d   = in_pl;
            skid_v_d = 1'b1;
          end
        end
        2'b11: if (out_fire) begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end
        // Skid-only is unreachable; fall back to empty if it ever shows up.
        default: begin
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
    // An invalid main entry must present a bubble to EX.
    if (!main_v_d) main_d[PW-1 -: CW] = '0;
    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             squash;

  always_comb begin
    // A flush only counts when it kills something: a held entry EX is not
    // taking this cycle, the skid entry, or an entry being accepted.
    squash      = flush & ((main_v_q & ~out_ready) | skid_v_q | (in_valid & rdy_q));
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_v_q && !out_ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (squash && !(&flush_cnt_q))                 flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
module tb_id_ex_elastic_reg;
  localparam int DW = 32, AW = 5, OW = 6, CW = OW + 8;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] npc, rd1, rd2, sig;
    logic [AW-1:0] rs, rt, rd;
  } pl_t;

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] npc;
    logic        eov, eir;
    logic [31:0] enpc;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  pl_t  in_pl = '0, out_pl;
  logic [CW-1:0] ctrl_out;
  logic [DW-1:0] npc_out, rd1_out, rd2_out, sigext_out;
  logic [AW-1:0] rs_out, rt_out, rd_out;
`ifdef ID_EX_PERF_CNT_EN
  logic [3:0] stall_cnt, flush_cnt;
`endif

  int n_chk = 0, n_fail = 0;
  pl_t mq[$];
  bit  m_rdy = 1'b0;

  always #5 clk = ~clk;

  id_ex_elastic_reg #(
    .DATA_W(DW), .REG_A_W(AW), .ALUOP_W(OW)
`ifdef ID_EX_PERF_CNT_EN
    ,.CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(in_pl.ctrl), .npc_in(in_pl.npc), .rd1_in(in_pl.rd1), .rd2_in(in_pl.rd2),
    .sigext_in(in_pl.sig), .rs_in(in_pl.rs), .rt_in(in_pl.rt), .rd_in(in_pl.rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .npc_out(npc_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
    .sigext_out(sigext_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out)
`ifdef ID_EX_PERF_CNT_EN
    ,.stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  assign out_pl = {ctrl_out, npc_out, rd1_out, rd2_out, sigext_out, rs_out, rt_out, rd_out};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pl_t mk(input logic [31:0] npc);
    pl_t p;
    p.ctrl = {npc[11:0], 2'b11};
    p.npc  = npc;
    p.rd1  = npc * 3;
    p.rd2  = ~npc;
    p.sig  = npc ^ 32'h1234_5678;
    p.rs   = npc[6:2];
    p.rt   = npc[4:0] ^ 5'h0A;
    p.rd   = npc[8:4];
    return p;
  endfunction

  function automatic pl_t mk_rand();
    pl_t p;
    p.ctrl = CW'($urandom); p.npc = $urandom; p.rd1 = $urandom; p.rd2 = $urandom;
    p.sig  = $urandom; p.rs = AW'($urandom); p.rt = AW'($urandom); p.rd = AW'($urandom);
    return p;
  endfunction

  // Called just after a negedge; applies inputs, advances the queue model
  // across the coming posedge and returns at the following negedge.
  task automatic drive(input logic iv, input logic ordy, input logic fl, input pl_t p);
    in_valid = iv; out_ready = ordy; flush = fl; in_pl = p;
    if (fl) mq.delete();
    else begin
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (iv && m_rdy) mq.push_back(p);
    end
    m_rdy = (mq.size() < 2);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    mq.delete();
    m_rdy = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ctrl_out",  ctrl_out,  '0);
    chk("rst_npc_out",   npc_out,   '0);
    chk("rst_in_ready",  in_ready,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic model_chk();
    chk("rnd_out_valid", out_valid, mq.size() > 0);
    chk("rnd_in_ready",  in_ready,  m_rdy);
    if (mq.size() > 0) chk("rnd_payload", out_pl, mq[0]);
    else               chk("rnd_bubble_ctrl", ctrl_out, '0);
  endtask

  vec_t tbl[17];
  pl_t  p5;

  initial begin
    // npc expectations only matter when eov=1
    tbl[0]  = '{1, 1, 0, 32'h04, 1, 1, 32'h04};
    tbl[1]  = '{1, 1, 0, 32'h08, 1, 1, 32'h08};
    tbl[2]  = '{1, 1, 0, 32'h0C, 1, 1, 32'h0C};
    tbl[3]  = '{0, 1, 0, 32'h00, 0, 1, 32'h00};
    tbl[4]  = '{1, 0, 0, 32'h10, 1, 1, 32'h10};
    tbl[5]  = '{1, 0, 0, 32'h14, 1, 0, 32'h10};
    tbl[6]  = '{1, 0, 0, 32'h18, 1, 0, 32'h10};
    tbl[7]  = '{1, 1, 0, 32'h18, 1, 1, 32'h14};
    tbl[8]  = '{1, 1, 0, 32'h18, 1, 1, 32'h18};
    tbl[9]  = '{0, 1, 0, 32'h00, 0, 1, 32'h00};
    tbl[10] = '{1, 0, 0, 32'h1C, 1, 1, 32'h1C};
    tbl[11] = '{1, 0, 0, 32'h24, 1, 0, 32'h1C};
    tbl[12] = '{1, 0, 1, 32'h20, 0, 1, 32'h00};
    tbl[13] = '{0, 1, 0, 32'h00, 0, 1, 32'h00};
    tbl[14] = '{1, 0, 0, 32'h28, 1, 1, 32'h28};
    tbl[15] = '{1, 0, 1, 32'h2C, 0, 1, 32'h00};
    tbl[16] = '{0, 1, 0, 32'h00, 0, 1, 32'h00};

    // Power-on reset
    #1;
    chk("por_out_valid", out_valid, 1'b0);
    chk("por_in_ready",  in_ready,  1'b0);
    chk("por_ctrl_out",  ctrl_out,  '0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, '0);
    chk("por_in_ready_after_edge", in_ready, 1'b1);

    // Streaming, back-pressure and flush vectors
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, mk(tbl[i].npc));
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].eov);
      chk($sformatf("vec%0d_in_ready", i),  in_ready,  tbl[i].eir);
      if (tbl[i].eov) chk($sformatf("vec%0d_payload", i), out_pl, mk(tbl[i].enpc));
      else            chk($sformatf("vec%0d_bubble", i),  ctrl_out, '0);
    end

    // Field integrity
    p5 = mk(32'h100);
    p5.rs = 5'h1F; p5.rt = 5'h0A; p5.rd = 5'h15; p5.rd1 = 32'hDEADBEEF;
    p5.ctrl = {3'b101, 6'h2A, 5'b10110};
    drive(1, 0, 0, p5);
    chk("fld_rs",     rs_out,  5'h1F);
    chk("fld_rt",     rt_out,  5'h0A);
    chk("fld_rd",     rd_out,  5'h15);
    chk("fld_alu_op", ctrl_out[10:5], 6'h2A);
    chk("fld_rd1",    rd1_out, 32'hDEADBEEF);
    chk("fld_all",    out_pl,  p5);

    // Mid-cycle reset with two entries held
    drive(1, 0, 0, mk(32'h200));
    chk("pre_rst_full", in_ready, 1'b0);
    do_reset();
    drive(0, 0, 0, '0);
    chk("rst_in_ready_after_edge", in_ready, 1'b1);
    chk("rst_still_empty", out_valid, 1'b0);

`ifdef ID_EX_PERF_CNT_EN
    do_reset();
    drive(0, 0, 0, '0);
    drive(1, 0, 0, mk(32'h40));
    for (int k = 0; k < 20; k++) drive(0, 0, 0, '0);
    chk("stall_cnt_sat", stall_cnt, 4'd15);
    chk("flush_cnt_zero", flush_cnt, 4'd0);
    drive(0, 0, 1, '0);
    chk("flush_cnt_one", flush_cnt, 4'd1);
    drive(0, 1, 1, '0);
    chk("flush_cnt_empty_flush", flush_cnt, 4'd1);
`endif

    // Randomized traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), mk_rand());
      model_chk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
